// File: rtl/conv_job_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_job_sequencer_pkg : opcodes, sequencer states, status-word layout
// Rev 1.0
// ---------------------------------------------------------------------------
package conv_job_sequencer_pkg;

  localparam logic [2:0] OPC_NOP      = 3'd0;
  localparam logic [2:0] OPC_SET_LEN  = 3'd1;
  localparam logic [2:0] OPC_LOAD_PIX = 3'd2;
  localparam logic [2:0] OPC_START    = 3'd3;
  localparam logic [2:0] OPC_READ_PIX = 3'd4;
  localparam logic [2:0] OPC_ABORT    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PROC = 3'd2,
    ST_DONE = 3'd3,
    ST_READ = 3'd4
  } state_t;

  localparam int STAT_STATE_LSB = 29;
  localparam int STAT_ERR_BIT   = 28;
  localparam int STAT_EOP_BIT   = 27;
  localparam int STAT_CNT_LSB   = 0;

endpackage
`default_nettype wire

// File: rtl/seq_cmd_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_cmd_decode : combinational opcode legality check for the current state
// Rev 1.0
// ---------------------------------------------------------------------------
module seq_cmd_decode
  import conv_job_sequencer_pkg::*;
(
  input  logic [2:0] i_opcode,
  input  state_t     i_state,
  input  logic       i_len_zero,
  input  logic       i_eop_seen,
  input  logic       i_changeBlock,
  output logic       o_legal
);

  always_comb begin
    o_legal = 1'b0;
    if (i_opcode == OPC_NOP || i_opcode == OPC_ABORT) begin
      o_legal = 1'b1;
    end else begin
      case (i_state)
        ST_IDLE: o_legal = (i_opcode == OPC_SET_LEN)
                        || (i_opcode == OPC_LOAD_PIX)
                        || (i_opcode == OPC_START    && !i_len_zero)
                        || (i_opcode == OPC_READ_PIX && i_eop_seen);
        // A block-complete in the same cycle pre-empts the pixel command
        ST_LOAD: o_legal = (i_opcode == OPC_LOAD_PIX) && !i_changeBlock;
        ST_READ: o_legal = (i_opcode == OPC_READ_PIX) && !i_changeBlock;
        default: o_legal = 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_job_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_job_sequencer : GPIO command sequencer driving the 2D-conv address FSM
// Rev 1.0
// ---------------------------------------------------------------------------
module conv_job_sequencer
  import conv_job_sequencer_pkg::*;
#(
  parameter int NB_GPIO   = 32,
  parameter int NB_IMAGE  = 10,
  parameter int NB_OPCODE = 3,
  parameter int NB_STATES = 3
)(
  input  logic                i_CLK,
  input  logic                i_reset,
  input  logic [NB_GPIO-1:0]  i_cmd,
  input  logic                i_cmd_vld,
  output logic                o_ready,
  output logic                o_ack,
  output logic [NB_GPIO-1:0]  o_status,
  output logic [NB_IMAGE-1:0] o_imgLength,
  output logic                o_load,
  output logic                o_SoP,
  output logic                o_valid,
  input  logic                i_EoP,
  input  logic                i_changeBlock
);

  state_t                r_state;
  logic                  r_ready, r_ack, r_load, r_sop, r_valid, r_err, r_eop_seen;
  logic [NB_IMAGE-1:0]   r_len, r_pix_cnt, w_pix_inc;
  logic [NB_OPCODE-1:0]  w_opcode;
  logic                  w_accept, w_legal, w_abort, w_cmd_unused;

  assign w_opcode     = i_cmd[NB_GPIO-1 -: NB_OPCODE];
  assign w_accept     = i_cmd_vld && r_ready;
  assign w_abort      = w_accept && (w_opcode == OPC_ABORT);
  assign w_pix_inc    = (&r_pix_cnt) ? r_pix_cnt : r_pix_cnt + 1'b1;
  assign w_cmd_unused = ^i_cmd[NB_GPIO-NB_OPCODE-1:NB_IMAGE];

  seq_cmd_decode u_decode (
    .i_opcode      (w_opcode),
    .i_state       (r_state),
    .i_len_zero    (r_len == '0),
    .i_eop_seen    (r_eop_seen),
    .i_changeBlock (i_changeBlock),
    .o_legal       (w_legal)
  );

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_ack      <= 1'b0;
      r_load     <= 1'b0;
      r_sop      <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_eop_seen <= 1'b0;
      r_len      <= '0;
      r_pix_cnt  <= '0;
    end else begin
      // Ready drops for one cycle after every accept so o_valid pulses are separated
      r_ack   <= w_accept;
      r_ready <= ~w_accept;
      r_valid <= 1'b0;
      if (w_abort) begin
        r_state    <= ST_IDLE;
        r_load     <= 1'b0;
        r_sop      <= 1'b0;
        r_pix_cnt  <= '0;
        r_eop_seen <= 1'b0;
      end else begin
        if (w_accept && !w_legal) r_err <= 1'b1;
        case (r_state)
          ST_IDLE: begin
            if (w_accept && w_legal) begin
              case (w_opcode)
                OPC_SET_LEN:  r_len <= i_cmd[NB_IMAGE-1:0];
                OPC_LOAD_PIX: begin
                  r_state   <= ST_LOAD;
                  r_load    <= 1'b1;
                  r_valid   <= 1'b1;
                  r_pix_cnt <= w_pix_inc;
                end
                OPC_START: begin
                  r_state <= ST_PROC;
                  r_sop   <= 1'b1;
                end
                OPC_READ_PIX: begin
                  r_state   <= ST_READ;
                  r_valid   <= 1'b1;
                  r_pix_cnt <= w_pix_inc;
                end
                default: ;
              endcase
            end
          end
          ST_LOAD: begin
            if (i_changeBlock) begin
              r_state   <= ST_IDLE;
              r_load    <= 1'b0;
              r_pix_cnt <= '0;
            end else if (w_accept && w_legal && w_opcode == OPC_LOAD_PIX) begin
              r_valid   <= 1'b1;
              r_pix_cnt <= w_pix_inc;
            end
          end
          ST_PROC: begin
            if (i_EoP) begin
              r_state    <= ST_DONE;
              r_sop      <= 1'b0;
              r_eop_seen <= 1'b1;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          ST_READ: begin
            if (i_changeBlock) begin
              r_state    <= ST_IDLE;
              r_pix_cnt  <= '0;
              r_eop_seen <= 1'b0;
            end else if (w_accept && w_legal && w_opcode == OPC_READ_PIX) begin
              r_valid   <= 1'b1;
              r_pix_cnt <= w_pix_inc;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    o_status = '0;
    o_status[STAT_STATE_LSB +: NB_STATES] = r_state;
    o_status[STAT_ERR_BIT]                = r_err;
    o_status[STAT_EOP_BIT]                = r_eop_seen;
    o_status[STAT_CNT_LSB +: NB_IMAGE]    = r_pix_cnt;
  end

  assign o_ready     = r_ready;
  assign o_ack       = r_ack;
  assign o_imgLength = r_len;
  assign o_load      = r_load;
  assign o_SoP       = r_sop;
  assign o_valid     = r_valid;

endmodule
`default_nettype wire
